// File: rtl/sync_filter.sv
// sync_filter: per-channel multi-flop synchronizer followed by a stability filter.
//
// Each channel samples an asynchronous level through a STAGES-deep flop chain.
// The last stage is the raw synchronized level. A new raw level is accepted into
// the filtered output only after it has differed from that output for
// FILTER_CYCLES consecutive edges. Each accepted edge produces a one-cycle pulse.
//
// Ports:
//   clk_sync_i  - single clock; all state changes on its rising edge
//   rst_i       - synchronous, active-high reset
//   sync_i      - asynchronous level inputs, one bit per channel
//   sync_o      - filtered level per channel (registered)
//   rise_o      - one-cycle pulse on an accepted 0->1 transition (registered)
//   fall_o      - one-cycle pulse on an accepted 1->0 transition (registered)
module sync_filter #(
   parameter int              WIDTH         = 8,
   parameter int              STAGES        = 2,
   parameter int              FILTER_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
   input  logic             clk_sync_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] sync_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   // A single-bit counter still works when FILTER_CYCLES is 1 or 2.
   localparam int CntW = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

   if (WIDTH < 1 || STAGES < 2 || FILTER_CYCLES < 1) begin : gen_param_check
      $error("sync_filter: illegal parameters WIDTH=%0d STAGES=%0d FILTER_CYCLES=%0d",
             WIDTH, STAGES, FILTER_CYCLES);
   end

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] stage_d [STAGES];
   logic [CntW-1:0]  cnt_q   [WIDTH];
   logic [CntW-1:0]  cnt_d   [WIDTH];
   logic [WIDTH-1:0] filt_q, filt_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] raw;

   assign raw = stage_q[STAGES-1];

   always_comb begin
      stage_d[0] = sync_i;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Any cycle where raw agrees with the filtered level restarts the count, so
   // only an unbroken run of FILTER_CYCLES mismatching edges is accepted.
   always_comb begin
      filt_d = filt_q;
      rise_d = '0;
      fall_d = '0;
      for (int c = 0; c < WIDTH; c++) begin
         cnt_d[c] = cnt_q[c];
         if (raw[c] == filt_q[c]) begin
            cnt_d[c] = '0;
         end else if (cnt_q[c] == CntMax) begin
            filt_d[c] = raw[c];
            cnt_d[c]  = '0;
            rise_d[c] = raw[c];
            fall_d[c] = ~raw[c];
         end else begin
            cnt_d[c] = cnt_q[c] + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_sync_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= RESET_VALUE;
         end
         for (int c = 0; c < WIDTH; c++) begin
            cnt_q[c] <= '0;
         end
         filt_q <= RESET_VALUE;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
         for (int c = 0; c < WIDTH; c++) begin
            cnt_q[c] <= cnt_d[c];
         end
         filt_q <= filt_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sync_o = filt_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter. Instance A: WIDTH=4, STAGES=2, FILTER_CYCLES=3,
// RESET_VALUE=0. Instance B: WIDTH=4, STAGES=3, FILTER_CYCLES=1, RESET_VALUE=4'hF.
// Tick index t counts edges from the edge that samples the new input (t=0); a level
// shows on sync_o after edge STAGES+FILTER_CYCLES-1 counted that way.
module tb_sync_filter;

   logic       clk;
   logic       rst;
   logic [3:0] sync_a, so_a, ro_a, fo_a;
   logic [3:0] sync_b, so_b, ro_b, fo_b;

   int n_cmp = 0;
   int n_bad = 0;

   sync_filter #(
      .WIDTH         (4),
      .STAGES        (2),
      .FILTER_CYCLES (3),
      .RESET_VALUE   (4'h0)
   ) u_dut_a (
      .clk_sync_i (clk),
      .rst_i      (rst),
      .sync_i     (sync_a),
      .sync_o     (so_a),
      .rise_o     (ro_a),
      .fall_o     (fo_a)
   );

   sync_filter #(
      .WIDTH         (4),
      .STAGES        (3),
      .FILTER_CYCLES (1),
      .RESET_VALUE   (4'hF)
   ) u_dut_b (
      .clk_sync_i (clk),
      .rst_i      (rst),
      .sync_i     (sync_b),
      .sync_o     (so_b),
      .rise_o     (ro_b),
      .fall_o     (fo_b)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      sync_a = 4'h0;
      rst    = 1'b1;
      tick();
      n_cmp++;
      if ({so_a, ro_a, fo_a} !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_a sync/rise/fall=%h %h %h expected 0 0 0", so_a, ro_a, fo_a);
      end
      n_cmp++;
      if ({so_b, ro_b, fo_b} !== 12'hF00) begin
         n_bad++;
         $display("FAIL reset_b sync/rise/fall=%h %h %h expected f 0 0", so_b, ro_b, fo_b);
      end
      rst = 1'b0;
      for (int t = 0; t < 3; t++) begin
         tick();
         n_cmp++;
         if ({so_a, ro_a, fo_a, so_b, ro_b, fo_b} !== 24'h000F00) begin
            n_bad++;
            $display("FAIL post_reset t=%0d a=%h %h %h b=%h %h %h expected a=0 0 0 b=f 0 0",
                     t, so_a, ro_a, fo_a, so_b, ro_b, fo_b);
         end
      end
   endtask

   task automatic test_single_rise();
      logic [3:0] exp_s, exp_r;
      sync_a = 4'b0001;
      for (int t = 0; t < 7; t++) begin
         tick();
         exp_s = (t >= 4) ? 4'b0001 : 4'b0000;
         exp_r = (t == 4) ? 4'b0001 : 4'b0000;
         n_cmp++;
         if (so_a !== exp_s || ro_a !== exp_r || fo_a !== 4'h0) begin
            n_bad++;
            $display("FAIL single_rise t=%0d sync/rise/fall=%h %h %h expected %h %h 0",
                     t, so_a, ro_a, fo_a, exp_s, exp_r);
         end
      end
   endtask

   task automatic test_glitch();
      for (int t = 0; t < 10; t++) begin
         sync_a = (t < 2) ? 4'b0010 : 4'b0000;
         tick();
         n_cmp++;
         if ({so_a, ro_a, fo_a} !== 12'h000) begin
            n_bad++;
            $display("FAIL glitch t=%0d sync/rise/fall=%h %h %h expected 0 0 0",
                     t, so_a, ro_a, fo_a);
         end
      end
   endtask

   // Pattern 1,1,0,1,1,1 (t=0 first), then held high.
   task automatic test_restart();
      logic [5:0] pat;
      logic [3:0] exp_s, exp_r;
      pat = 6'b111011;
      for (int t = 0; t < 10; t++) begin
         sync_a = {1'b0, (t < 6) ? pat[t] : 1'b1, 2'b00};
         tick();
         exp_s = (t >= 7) ? 4'b0100 : 4'b0000;
         exp_r = (t == 7) ? 4'b0100 : 4'b0000;
         n_cmp++;
         if (so_a !== exp_s || ro_a !== exp_r || fo_a !== 4'h0) begin
            n_bad++;
            $display("FAIL restart t=%0d sync/rise/fall=%h %h %h expected %h %h 0",
                     t, so_a, ro_a, fo_a, exp_s, exp_r);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_s, exp_r, exp_f;
      for (int t = 0; t < 20; t++) begin
         sync_a = (t < 10) ? 4'hF : 4'h0;
         tick();
         exp_s = (t >= 4 && t < 14) ? 4'hF : 4'h0;
         exp_r = (t == 4) ? 4'hF : 4'h0;
         exp_f = (t == 14) ? 4'hF : 4'h0;
         n_cmp++;
         if (so_a !== exp_s || ro_a !== exp_r || fo_a !== exp_f) begin
            n_bad++;
            $display("FAIL back_to_back t=%0d sync/rise/fall=%h %h %h expected %h %h %h",
                     t, so_a, ro_a, fo_a, exp_s, exp_r, exp_f);
         end
      end
   endtask

   // Reset lands on edge 4, where the run would otherwise have been accepted.
   task automatic test_reset_mid_run();
      logic [3:0] exp_s, exp_r;
      sync_a = 4'b0001;
      for (int t = 0; t < 11; t++) begin
         rst = (t == 4);
         tick();
         exp_s = (t >= 9) ? 4'b0001 : 4'b0000;
         exp_r = (t == 9) ? 4'b0001 : 4'b0000;
         n_cmp++;
         if (so_a !== exp_s || ro_a !== exp_r || fo_a !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_mid_run t=%0d sync/rise/fall=%h %h %h expected %h %h 0",
                     t, so_a, ro_a, fo_a, exp_s, exp_r);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_fc1();
      logic [3:0] exp_s, exp_f;
      for (int t = 0; t < 5; t++) begin
         sync_b = 4'h7;
         tick();
         exp_s = (t >= 3) ? 4'h7 : 4'hF;
         exp_f = (t == 3) ? 4'h8 : 4'h0;
         n_cmp++;
         if (so_b !== exp_s || ro_b !== 4'h0 || fo_b !== exp_f) begin
            n_bad++;
            $display("FAIL fc1 t=%0d sync/rise/fall=%h %h %h expected %h 0 %h",
                     t, so_b, ro_b, fo_b, exp_s, exp_f);
         end
      end
   endtask

   initial begin
      clk    = 1'b0;
      rst    = 1'b0;
      sync_a = 4'h0;
      sync_b = 4'hF;
      tick();
      test_reset();
      test_single_rise();
      test_reset();
      test_glitch();
      test_reset();
      test_restart();
      test_reset();
      test_back_to_back();
      test_reset();
      test_reset_mid_run();
      test_fc1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
